// File: rtl/gigatron_cpu.sv
// Gigatron-style 8-bit TTL CPU core.
// Runs a two-phase sequencer with one instruction every two clocks. There is
// no pipeline stall: the instruction after a jump (the delay slot) always
// executes.
//
// state   | meaning
// --------|-----------------------------------------------------------------
// ST_ADDR | RAM address driven from IR/D/X/Y, PC advances, no reg writes
// ST_EXEC | ROM/RAM data valid, registers and RAM written, next IR latched
module gigatron_cpu #(
  parameter int ROM_AW = 16,
  parameter int RAM_AW = 15,
  parameter logic [ROM_AW-1:0] RESET_PC = '0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  output logic [ROM_AW-1:0] o_Rom_Addr,
  input  logic [15:0]       i_Rom_Data,
  output logic [RAM_AW-1:0] o_Ram_Addr,
  output logic              o_Ram_Wr,
  output logic [7:0]        o_Ram_Wr_Data,
  input  logic [7:0]        i_Ram_Rd_Data,
  input  logic [7:0]        i_In,
  output logic [7:0]        o_Out,
  output logic [7:0]        o_Xout,
  output logic [7:0]        o_AC,
  output logic              o_Retire
);

  typedef enum logic {ST_ADDR, ST_EXEC} state_t;

  state_t            state_q;
  logic [ROM_AW-1:0] pc_q;
  logic [7:0]        ir_q;
  logic [7:0]        d_q;
  logic [7:0]        ac_q;
  logic [7:0]        x_q;
  logic [7:0]        y_q;
  logic [7:0]        out_q;
  logic [7:0]        xout_q;

  logic [2:0]        op;
  logic [2:0]        mode;
  logic [1:0]        bus_sel;
  logic [7:0]        bus;
  logic [7:0]        alu;
  logic [7:0]        ram_hi;
  logic [7:0]        ram_lo;
  logic              taken;
  logic [7:0]        slot_page;
  logic [7:0]        jump_hi;
  logic [ROM_AW-1:0] jump_pc;
  logic              is_exec;

  assign op      = ir_q[7:5];
  assign mode    = ir_q[4:2];
  assign bus_sel = ir_q[1:0];
  assign is_exec = (state_q == ST_EXEC);

  // Data address: jumps read [D]; everything else decodes the mode field.
  always_comb begin
    ram_hi = 8'h00;
    ram_lo = d_q;
    if (op != 3'd7) begin
      case (mode)
        3'd1:         begin ram_hi = 8'h00; ram_lo = x_q; end
        3'd2:         begin ram_hi = y_q;   ram_lo = d_q; end
        3'd3, 3'd7:   begin ram_hi = y_q;   ram_lo = x_q; end
        default:      begin ram_hi = 8'h00; ram_lo = d_q; end
      endcase
    end
  end

  // Bus source mux.
  always_comb begin
    case (bus_sel)
      2'd0:    bus = d_q;
      2'd1:    bus = i_Ram_Rd_Data;
      2'd2:    bus = ac_q;
      default: bus = i_In;
    endcase
  end

  // ALU: plain 8-bit modulo arithmetic, no flags.
  always_comb begin
    case (op)
      3'd1:    alu = ac_q & bus;
      3'd2:    alu = ac_q | bus;
      3'd3:    alu = ac_q ^ bus;
      3'd4:    alu = ac_q + bus;
      3'd5:    alu = ac_q - bus;
      default: alu = bus;
    endcase
  end

  // Branch condition on AC treated as signed; mode 0 is the unconditional far jump.
  always_comb begin
    case (mode)
      3'd1:    taken = !ac_q[7] && (ac_q != 8'h00);
      3'd2:    taken = ac_q[7];
      3'd3:    taken = (ac_q != 8'h00);
      3'd4:    taken = (ac_q == 8'h00);
      3'd5:    taken = !ac_q[7];
      3'd6:    taken = ac_q[7] || (ac_q == 8'h00);
      default: taken = 1'b1;
    endcase
  end

  // During EXEC the PC already points two past the branch, so the delay-slot
  // address (branch+1) is PC-1; near branches stay in that page.
  assign slot_page = 8'(16'(pc_q - ROM_AW'(1)) >> 8);
  assign jump_hi   = (mode == 3'd0) ? y_q : slot_page;
  assign jump_pc   = ROM_AW'({jump_hi, bus});

  // Sequencer and architectural register updates.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_ADDR;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h02;
      d_q     <= 8'h00;
      ac_q    <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      out_q   <= 8'h00;
      xout_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_ADDR: begin
          pc_q    <= pc_q + ROM_AW'(1);
          state_q <= ST_EXEC;
        end
        default: begin
          state_q <= ST_ADDR;
          ir_q    <= i_Rom_Data[15:8];
          d_q     <= i_Rom_Data[7:0];
          if (op <= 3'd5) begin
            case (mode)
              3'd4:       x_q   <= alu;
              3'd5:       y_q   <= alu;
              3'd6, 3'd7: out_q <= alu;
              default:    ac_q  <= alu;
            endcase
            if (mode == 3'd7) x_q <= x_q + 8'd1;
            if ((mode >= 3'd6) && alu[6] && !out_q[6]) xout_q <= ac_q;
          end else if (op == 3'd6) begin
            if (mode == 3'd4) x_q <= bus;
            if (mode == 3'd5) y_q <= bus;
            if (mode == 3'd7) x_q <= x_q + 8'd1;
          end else begin
            if (taken) pc_q <= jump_pc;
          end
        end
      endcase
    end
  end

  assign o_Rom_Addr    = pc_q;
  assign o_Ram_Addr    = RAM_AW'({ram_hi, ram_lo});
  // Reset is sampled on the edge, so the strobe is gated to keep a store
  // caught by reset from writing.
  assign o_Ram_Wr      = is_exec && (op == 3'd6) && (bus_sel != 2'd1) && !i_Reset;
  assign o_Ram_Wr_Data = bus;
  assign o_Out         = out_q;
  assign o_Xout        = xout_q;
  assign o_AC          = ac_q;
  assign o_Retire      = is_exec;

endmodule

// File: tb/tb_gigatron_cpu.sv
// Directed bench for gigatron_cpu: a straight-line program table plus
// hand-written branch, jump and reset sequences.
module tb_gigatron_cpu;

  logic        clk;
  logic        rst;
  logic [15:0] rom_addr;
  logic [15:0] rom_q;
  logic [14:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_wr_data;
  logic [7:0]  ram_q;
  logic [7:0]  in_v;
  logic [7:0]  out_v, xout_v, ac_v;
  logic        retire;

  logic [9:0]  d2_rom_addr;
  logic [14:0] d2_ram_addr;
  logic        d2_ram_wr, d2_retire;
  logic [7:0]  d2_wr_data, d2_out, d2_xout, d2_ac;

  int tests = 0;
  int fails = 0;

  logic [15:0] rom [0:65535];
  logic [7:0]  ram_init [0:32767];
  logic [14:0] wr_addr [0:15];
  logic [7:0]  wr_data [0:15];
  int          wr_cnt = 0;

  gigatron_cpu dut (
    .i_Clk(clk), .i_Reset(rst), .o_Rom_Addr(rom_addr), .i_Rom_Data(rom_q),
    .o_Ram_Addr(ram_addr), .o_Ram_Wr(ram_wr), .o_Ram_Wr_Data(ram_wr_data),
    .i_Ram_Rd_Data(ram_q), .i_In(in_v), .o_Out(out_v), .o_Xout(xout_v),
    .o_AC(ac_v), .o_Retire(retire)
  );

  gigatron_cpu #(.ROM_AW(10), .RESET_PC(10'h3FF)) dut2 (
    .i_Clk(clk), .i_Reset(rst), .o_Rom_Addr(d2_rom_addr), .i_Rom_Data(16'h0200),
    .o_Ram_Addr(d2_ram_addr), .o_Ram_Wr(d2_ram_wr), .o_Ram_Wr_Data(d2_wr_data),
    .i_Ram_Rd_Data(8'h00), .i_In(8'h00), .o_Out(d2_out), .o_Xout(d2_xout),
    .o_AC(d2_ac), .o_Retire(d2_retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_lookup(input logic [14:0] a);
    logic [7:0] v;
    v = ram_init[a];
    for (int i = 0; i < 16; i++)
      if (i < wr_cnt && wr_addr[i] == a) v = wr_data[i];
    return v;
  endfunction

  // Synchronous ROM/RAM models: data valid one clock after the address.
  always @(posedge clk) begin
    rom_q <= rom[rom_addr];
    ram_q <= ram_lookup(ram_addr);
    if (ram_wr && wr_cnt < 16) begin
      wr_addr[wr_cnt] <= ram_addr;
      wr_data[wr_cnt] <= ram_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 65536; i++) rom[i] = 16'h0200;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for the next EXEC phase and returns 1ns after its closing edge.
  task automatic wait_retire();
    int n;
    n = 0;
    @(negedge clk);
    while (!retire && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!retire) check("retire_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  ac, x, y, out, xout;
    int          wr;
  } vec_t;

  vec_t        vecs [26];
  logic [6:0]  masks [3];
  logic [7:0]  acvals [3];
  logic [7:0]  opw;
  int          wr_before;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 instr     ac     x      y      out    xout   wr
    vecs[0]  = '{16'h0005, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 0};
    vecs[1]  = '{16'h8003, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 0};
    vecs[2]  = '{16'h1010, 8'h08, 8'h10, 8'h00, 8'h00, 8'h00, 0};
    vecs[3]  = '{16'h1401, 8'h08, 8'h10, 8'h01, 8'h00, 8'h00, 0};
    vecs[4]  = '{16'h005A, 8'h5A, 8'h10, 8'h01, 8'h00, 8'h00, 0};
    vecs[5]  = '{16'hDE00, 8'h5A, 8'h11, 8'h01, 8'h00, 8'h00, 1};
    vecs[6]  = '{16'h200F, 8'h0A, 8'h11, 8'h01, 8'h00, 8'h00, 1};
    vecs[7]  = '{16'h40F0, 8'hFA, 8'h11, 8'h01, 8'h00, 8'h00, 1};
    vecs[8]  = '{16'h60FF, 8'h05, 8'h11, 8'h01, 8'h00, 8'h00, 1};
    vecs[9]  = '{16'hA006, 8'hFF, 8'h11, 8'h01, 8'h00, 8'h00, 1};
    vecs[10] = '{16'h8002, 8'h01, 8'h11, 8'h01, 8'h00, 8'h00, 1};
    vecs[11] = '{16'h0300, 8'hA5, 8'h11, 8'h01, 8'h00, 8'h00, 1};
    vecs[12] = '{16'h0910, 8'h5A, 8'h11, 8'h01, 8'h00, 8'h00, 1};
    vecs[13] = '{16'h1200, 8'h5A, 8'h5A, 8'h01, 8'h00, 8'h00, 1};
    vecs[14] = '{16'h6500, 8'h69, 8'h5A, 8'h01, 8'h00, 8'h00, 1};
    vecs[15] = '{16'h003C, 8'h3C, 8'h5A, 8'h01, 8'h00, 8'h00, 1};
    vecs[16] = '{16'h1840, 8'h3C, 8'h5A, 8'h01, 8'h40, 8'h3C, 1};
    vecs[17] = '{16'h1840, 8'h3C, 8'h5A, 8'h01, 8'h40, 8'h3C, 1};
    vecs[18] = '{16'h1800, 8'h3C, 8'h5A, 8'h01, 8'h00, 8'h3C, 1};
    vecs[19] = '{16'h10FF, 8'h3C, 8'hFF, 8'h01, 8'h00, 8'h3C, 1};
    vecs[20] = '{16'h1D00, 8'h3C, 8'h00, 8'h01, 8'h81, 8'h3C, 1};
    vecs[21] = '{16'h0055, 8'h55, 8'h00, 8'h01, 8'h81, 8'h3C, 1};
    vecs[22] = '{16'h1840, 8'h55, 8'h00, 8'h01, 8'h40, 8'h55, 1};
    vecs[23] = '{16'hD15A, 8'h55, 8'h33, 8'h01, 8'h40, 8'h55, 1};
    vecs[24] = '{16'hD630, 8'h55, 8'h33, 8'h55, 8'h40, 8'h55, 2};
    vecs[25] = '{16'h0200, 8'h55, 8'h33, 8'h55, 8'h40, 8'h55, 2};

    // Taken flags per branch mode (bit m-1) for AC = 0x00, 0x01, 0x80.
    acvals[0] = 8'h00; masks[0] = 7'h78;
    acvals[1] = 8'h01; masks[1] = 7'h55;
    acvals[2] = 8'h80; masks[2] = 7'h66;

    for (int i = 0; i < 32768; i++) ram_init[i] = 8'h00;
    ram_init[15'h005A] = 8'h33;
    ram_init[15'h01FF] = 8'h81;

    clear_rom();
    for (int i = 0; i < 26; i++) rom[i] = vecs[i].instr;
    in_v = 8'hA5;
    rst  = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_pc", 32'(rom_addr), 32'h0000);
    check("rst_ac_out_xout", {8'h00, ac_v, out_v, xout_v}, 32'h0);
    check("rst_wr_retire", {30'h0, ram_wr, retire}, 32'h0);
    check("rst_xy", {16'h0, dut.x_q, dut.y_q}, 32'h0);
    check("rst_pc_aw10", 32'(d2_rom_addr), 32'h3FF);
    check("rst_aw10_regs", {d2_ac, d2_xout, d2_out, d2_wr_data}, 32'h0);
    check("rst_aw10_ctl", {16'h0, d2_ram_wr, d2_retire, d2_ram_addr[13:0]}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("pc_after_addr", 32'(rom_addr), 32'h0001);
    check("pc_wrap_aw10", 32'(d2_rom_addr), 32'h000);
    wait_retire();  // reset nop
    check("nop_ac", 32'(ac_v), 32'h00);

    // Straight-line program table.
    for (int i = 0; i < 26; i++) begin
      wait_retire();
      check($sformatf("v%0d_ac", i), 32'(ac_v), 32'(vecs[i].ac));
      check($sformatf("v%0d_x", i), 32'(dut.x_q), 32'(vecs[i].x));
      check($sformatf("v%0d_y", i), 32'(dut.y_q), 32'(vecs[i].y));
      check($sformatf("v%0d_out", i), 32'(out_v), 32'(vecs[i].out));
      check($sformatf("v%0d_xout", i), 32'(xout_v), 32'(vecs[i].xout));
      check($sformatf("v%0d_wrcnt", i), 32'(wr_cnt), 32'(vecs[i].wr));
    end
    check("wr0_addr", 32'(wr_addr[0]), 32'h0110);
    check("wr0_data", 32'(wr_data[0]), 32'h5A);
    check("wr1_addr", 32'(wr_addr[1]), 32'h0030);
    check("wr1_data", 32'(wr_data[1]), 32'h55);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("retire_toggle%0d", i), 32'(retire), 32'(i % 2));
    end

    // beq taken with delay slot, then not taken.
    clear_rom();
    rom[5] = 16'hF020; rom[6] = 16'h0077; rom[7] = 16'h0011; rom[16'h20] = 16'h0022;
    do_reset();
    repeat (7) wait_retire();
    check("beq_taken_pc", 32'(rom_addr), 32'h0020);
    wait_retire();
    check("beq_slot_ac", 32'(ac_v), 32'h77);
    wait_retire();
    check("beq_target_ac", 32'(ac_v), 32'h22);
    rom[0] = 16'h0001;
    do_reset();
    repeat (7) wait_retire();
    check("beq_fall_pc", 32'(rom_addr), 32'h0007);
    wait_retire();
    check("beq_fall_slot_ac", 32'(ac_v), 32'h77);
    wait_retire();
    check("beq_fall_next_ac", 32'(ac_v), 32'h11);

    // Every condition against zero, positive and negative AC.
    for (int a = 0; a < 3; a++) begin
      for (int m = 1; m < 8; m++) begin
        clear_rom();
        opw = 8'hE0 | 8'(m << 2);
        rom[0] = {8'h00, acvals[a]};
        rom[1] = {opw, 8'h40};
        do_reset();
        repeat (3) wait_retire();
        check($sformatf("cond_m%0d_ac%0h", m, acvals[a]), 32'(rom_addr),
              masks[a][m-1] ? 32'h0040 : 32'h0003);
      end
    end

    // Far jump, near branch across a page boundary, far jump using Y.
    clear_rom();
    rom[0] = 16'hE0FE; rom[1] = 16'h1412; rom[16'hFF] = 16'hFC10; rom[16'h110] = 16'hE034;
    do_reset();
    repeat (2) wait_retire();
    check("far_jmp_pc", 32'(rom_addr), 32'h00FE);
    repeat (3) wait_retire();
    check("bra_page_cross_pc", 32'(rom_addr), 32'h0110);
    repeat (2) wait_retire();
    check("far_jmp_y_pc", 32'(rom_addr), 32'h1234);

    // Reset arriving during the EXEC of a store.
    clear_rom();
    rom[0] = 16'h00AA; rom[1] = 16'h1012; rom[2] = 16'hC200;
    do_reset();
    repeat (3) wait_retire();
    wr_before = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    check("store_exec_wr", {30'h0, retire, ram_wr}, 32'h3);
    rst = 1'b1;
    #1;
    check("rst_store_wr", 32'(ram_wr), 32'h0);
    @(posedge clk);
    #1;
    check("rst_store_wrcnt", 32'(wr_cnt), 32'(wr_before));
    check("rst_store_pc", 32'(rom_addr), 32'h0000);
    check("rst_store_regs", {ac_v, dut.x_q, out_v, xout_v}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gigatron_cpu.md
GIGATRON_CPU -- requirements
Module: gigatron_cpu

Interface
REQ-001 SHALL have parameter ROM_AW, default 16, ROM word-address width (PC width).
REQ-002 SHALL have parameter RAM_AW, default 15, RAM byte-address width; 16-bit internal addresses truncated to RAM_AW LSBs.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have i_Clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have i_Reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have o_Rom_Addr  out  ROM_AW  fetch address, equal to PC register at all times.
REQ-007 SHALL have i_Rom_Data  in  16  instruction word, [15:8]=IR (op[7:5], mode[4:2], bus[1:0]), [7:0]=D; valid one clock after address.
REQ-008 SHALL have o_Ram_Addr  out  RAM_AW  data address, combinational from IR, D, X, Y.
REQ-009 SHALL have o_Ram_Wr / o_Ram_Wr_Data  out  1 / 8  write strobe and byte.
REQ-010 SHALL have i_Ram_Rd_Data  in  8  read byte, valid one clock after address.
REQ-011 SHALL have i_In  in  8  input port (externally synchronised).
REQ-012 SHALL have o_Out / o_Xout / o_AC  out  8 each  OUT register, extended output, accumulator (debug/7-seg).
REQ-013 SHALL have o_Retire  out  1  high exactly during EXEC phase.

Function
REQ-014 Two-phase sequencer, states ADDR -> EXEC -> ADDR; one instruction per 2 clocks.
REQ-015 ADDR: RAM address presented for IR; PC <= PC+1 (mod 2^ROM_AW); no architectural register written.
REQ-016 EXEC: i_Rom_Data holds next instruction, i_Ram_Rd_Data valid; registers updated; IR/D <= i_Rom_Data at end of EXEC.
REQ-017 Bus source: 0=D, 1=RAM read, 2=AC, 3=i_In.
REQ-018 Ops 0-5: result = bus, AC&bus, AC|bus, AC^bus, AC+bus, AC-bus; 8-bit modulo, no flags.
REQ-019 ALU modes: 0 [D]->AC, 1 [X]->AC, 2 [Y,D]->AC, 3 [Y,X]->AC, 4 [D]->X, 5 [D]->Y, 6 [D]->OUT, 7 [Y,X]->OUT then X<=X+1 (mod 256).
REQ-020 Op 6 (store): o_Ram_Wr high in EXEC only, data=bus; address per mode ([D] for 0,4,5,6); mode 4/5 also load X/Y with bus; mode 7 X<=X+1; AC unchanged.
REQ-021 Store with bus=1: no write; all other side effects kept.
REQ-022 Op 7 (jump): RAM read address [D]; mode 0 far: PC <= {Y,bus}; modes 1-7 target {page of branch address+1, bus}.
REQ-023 Conditions on signed AC: 1 >0, 2 <0, 3 !=0, 4 ==0, 5 >=0, 6 <=0, 7 always.
REQ-024 Taken branch overrides the ADDR-phase increment; instruction after the branch (delay slot) always executes.
REQ-025 Target wider than ROM_AW truncated to ROM_AW LSBs.
REQ-026 o_Xout <= AC in the EXEC where OUT[6] goes 0->1 (hsync rising); AC value before that instruction's update.
REQ-027 o_Ram_Wr low whenever not EXEC or op!=6.

Reset
REQ-028 i_Reset high: PC<=RESET_PC, IR/D<=0x0200 (nop), state<=ADDR, AC=X=Y=OUT=XOUT=0, o_Ram_Wr=0.
REQ-029 Reset wins over any in-flight instruction, including EXEC with pending store (no write).
REQ-030 First instruction executed after reset release is the nop; instruction at RESET_PC retires on second o_Retire.

Verification
REQ-031 ROM @0: 0x0005 (ld $05), 0x8003 (add $03) -> after 3rd retire AC=0x08; o_Retire toggles every clock.
REQ-032 X=0x10, Y=0x01, AC=0x5A, store 0xDE00 (st [y,x++],ac=mode 7) -> write addr 0x0110 data 0x5A, then X=0x11.
REQ-033 AC=0x00, beq target 0x20 at 0x0005, slot ld $77 at 0x0006 -> AC=0x77 then next retire from 0x0020; with AC=0x01 falls through to 0x0007.
REQ-034 OUT=0x00, AC=0x3C, ld $40,out -> o_Out=0x40, o_Xout=0x3C; second ld $40,out leaves o_Xout unchanged.
REQ-035 i_Reset during EXEC of store -> o_Ram_Wr stays 0, next fetch RESET_PC, all registers 0.
REQ-036 X=0xFF, ld [y,x++],out -> X=0x00; ROM_AW=10, PC=0x3FF -> next fetch 0x000.
